// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles the requester-side and uart_tx-side signals of uart_tx_arbiter.
// Ports  : req_valid_in/req_data_in/req_last_in/req_ready_out per requester;
//          tx_data_out/tx_enable_out/tx_busy_in/tx_done_in to uart_tx; grant/lock/timeout status.
// Modports: slave = arbiter view, master = producer/uart_tx/testbench view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid_in;
    logic [8*NUM_REQ-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_last_in;
    logic [NUM_REQ-1:0]   req_ready_out;
    logic [7:0]           tx_data_out;
    logic                 tx_enable_out;
    logic                 tx_busy_in;
    logic                 tx_done_in;
    logic [GW-1:0]        grant_out;
    logic                 locked_out;
    logic [15:0]          timeout_count_out;

    modport slave (
        input  req_valid_in, req_data_in, req_last_in, tx_busy_in, tx_done_in,
        output req_ready_out, tx_data_out, tx_enable_out, grant_out, locked_out,
               timeout_count_out
    );

    modport master (
        output req_valid_in, req_data_in, req_last_in, tx_busy_in, tx_done_in,
        input  req_ready_out, tx_data_out, tx_enable_out, grant_out, locked_out,
               timeout_count_out
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin, packet-locked sharing of one uart_tx between NUM_REQ byte sources.
// Latency: enable/ready pulse one cycle after a qualifying valid; next byte two cycles after done.
// Backpressure: no launch while tx_busy_in=1 or a byte is in flight; locked packets hold the grant.
// Ports: clk_in, rst_n_in (async active-low); bus (slave modport) carries requester and uart_tx signals.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1_000_000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [7:0]          data_q, data_d;
    logic                last_q, last_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                enable_q, enable_d;
    logic                locked_q, locked_d;
    logic [CW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;

    logic [7:0]          req_byte [NUM_REQ];
    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [GW-1:0]       cand;
    logic                do_launch;
    logic [GW-1:0]       launch_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = bus.req_data_in[8*gi +: 8];
    end

    // Rotating priority: search starts just after the last packet's owner and
    // wraps at NUM_REQ-1, so non-power-of-2 counts never select a ghost index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.req_valid_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        last_d     = last_q;
        ready_d    = '0;
        enable_d   = 1'b0;
        locked_d   = locked_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        do_launch  = 1'b0;
        launch_idx = win_idx;

        case (state_q)
            IDLE: begin
                if (win_found && !bus.tx_busy_in) begin
                    do_launch  = 1'b1;
                    launch_idx = win_idx;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done_in) begin
                    if (last_q) begin
                        locked_d = 1'b0;
                        ptr_d    = grant_q;
                        state_d  = IDLE;
                    end else begin
                        locked_d   = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the lock owner may continue; everyone else waits.
                if (bus.req_valid_in[grant_q] && !bus.tx_busy_in) begin
                    do_launch  = 1'b1;
                    launch_idx = grant_q;
                end else if (hold_cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
                    locked_d = 1'b0;
                    ptr_d    = grant_q;
                    state_d  = IDLE;
                    if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared launch path for IDLE and HOLD: everything registers together so
        // enable, ready, grant and data appear in the same cycle.
        if (do_launch) begin
            state_d             = WAIT_DONE;
            grant_d             = launch_idx;
            data_d              = req_byte[launch_idx];
            last_d              = bus.req_last_in[launch_idx];
            ready_d[launch_idx] = 1'b1;
            enable_d            = 1'b1;
            // A last byte sent under lock keeps locked_out high until its done.
            locked_d            = locked_q | ~bus.req_last_in[launch_idx];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            ptr_q      <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            ready_q    <= '0;
            enable_q   <= 1'b0;
            locked_q   <= 1'b0;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            enable_q   <= enable_d;
            locked_q   <= locked_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign bus.req_ready_out     = ready_q;
    assign bus.tx_data_out       = data_q;
    assign bus.tx_enable_out     = enable_q;
    assign bus.grant_out         = grant_q;
    assign bus.locked_out        = locked_q;
    assign bus.timeout_count_out = tmo_cnt_q;
endmodule
